// File: rtl/runner_pkg.sv
// Shared types and widths for the runner / frame scheduler slice.
package runner_pkg;

    localparam int unsigned SCHED_FRAME_W = 16;
    localparam int unsigned SCHED_OVR_W   = 8;

    typedef enum logic [1:0] {
        IDLE,
        PAINT,
        TICK
    } sched_state_t;

    function automatic logic [SCHED_OVR_W-1:0] sat_inc_ovr(input logic [SCHED_OVR_W-1:0] v);
        return (v == '1) ? v : v + 1'b1;
    endfunction

endpackage

// File: rtl/edge_rise.sv
// Registered rising-edge detector; output pulses one cycle after the input rises.
module edge_rise (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic d_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            d_q  <= 1'b0;
            rise <= 1'b0;
        end else begin
            d_q  <= d;
            rise <= d & ~d_q;
        end
    end

endmodule

// File: rtl/frame_scheduler.sv
// Per-frame sequencer: launch painter, wait for completion, then hand a logic tick to the runner.
// Frame/overrun statistics are built only when FRAME_SCHED_STATS_EN is defined.
module frame_scheduler
    import runner_pkg::*;
#(
    parameter int unsigned FRAME_DIV     = 2,
    parameter int unsigned PAINT_TIMEOUT = 500000,
    parameter int unsigned FINISH_MASK   = 2
) (
    input  logic                     clk_33m,
    input  logic                     reset_n,
    input  logic                     frame_start,
    input  logic                     painter_finished,
    input  logic                     tick_ack,
    input  logic                     pause,
    input  logic                     step,
    output logic                     paint_start,
    output logic                     tick_req,
    output logic                     busy,
    output logic [SCHED_FRAME_W-1:0] frame_count,
    output logic [SCHED_OVR_W-1:0]   overrun_count
);

    localparam int unsigned DIV_W = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
    localparam int unsigned CNT_W = $clog2(PAINT_TIMEOUT + 1);

    sched_state_t     state_q, state_d;
    logic [DIV_W-1:0] div_cnt_q, div_cnt_d;
    logic [CNT_W-1:0] cyc_q, cyc_d;
    logic             tick_due_q, tick_due_d;
    logic             step_pending_q, step_pending_d;
    logic             frame_pending_q, frame_pending_d;
    logic             step_rise;
    logic             finish_ok;
    logic             timeout;

    edge_rise u_step_edge (
        .clk   (clk_33m),
        .rst_n (reset_n),
        .d     (step),
        .rise  (step_rise)
    );

    // The painter's done level may still be high from the previous frame for a couple of cycles.
    assign finish_ok = (state_q == PAINT) && painter_finished && (cyc_q >= CNT_W'(FINISH_MASK));
    assign timeout   = (state_q == PAINT) && (cyc_q == CNT_W'(PAINT_TIMEOUT - 1));

    always_comb begin
        state_d         = state_q;
        div_cnt_d       = div_cnt_q;
        cyc_d           = cyc_q;
        tick_due_d      = tick_due_q;
        step_pending_d  = step_pending_q;
        frame_pending_d = frame_pending_q;
        paint_start     = 1'b0;

        unique case (state_q)
            IDLE: begin
                if (frame_start || frame_pending_q) begin
                    paint_start     = 1'b1;
                    frame_pending_d = 1'b0;
                    state_d         = PAINT;
                end
            end
            PAINT: begin
                cyc_d = cyc_q + 1'b1;
                if (finish_ok) begin
                    state_d = tick_due_q ? TICK : IDLE;
                    if (frame_start) begin
                        frame_pending_d = 1'b1;
                    end
                end else if (frame_start) begin
                    paint_start = 1'b1;
                end else if (timeout) begin
                    state_d = IDLE;
                end
            end
            TICK: begin
                if (frame_start) begin
                    frame_pending_d = 1'b1;
                end
                if (tick_ack) begin
                    step_pending_d = 1'b0;
                    state_d        = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase

        // Every launch (fresh or overrun restart) advances the divider and re-decides the tick.
        if (paint_start) begin
            tick_due_d = (div_cnt_q == '0) && (!pause || step_pending_q);
            div_cnt_d  = (div_cnt_q == DIV_W'(FRAME_DIV - 1)) ? '0 : div_cnt_q + 1'b1;
            cyc_d      = '0;
        end

        if (step_rise && pause) begin
            step_pending_d = 1'b1;
        end
    end

    always_ff @(posedge clk_33m or negedge reset_n) begin
        if (!reset_n) begin
            state_q         <= IDLE;
            div_cnt_q       <= '0;
            cyc_q           <= '0;
            tick_due_q      <= 1'b0;
            step_pending_q  <= 1'b0;
            frame_pending_q <= 1'b0;
        end else begin
            state_q         <= state_d;
            div_cnt_q       <= div_cnt_d;
            cyc_q           <= cyc_d;
            tick_due_q      <= tick_due_d;
            step_pending_q  <= step_pending_d;
            frame_pending_q <= frame_pending_d;
        end
    end

    assign tick_req = (state_q == TICK);
    assign busy     = (state_q != IDLE);

`ifdef FRAME_SCHED_STATS_EN
    logic                     overrun;
    logic [SCHED_FRAME_W-1:0] frame_cnt_q;
    logic [SCHED_OVR_W-1:0]   ovr_cnt_q;

    assign overrun = (state_q == PAINT) && !finish_ok && (frame_start || timeout);

    always_ff @(posedge clk_33m or negedge reset_n) begin
        if (!reset_n) begin
            frame_cnt_q <= '0;
            ovr_cnt_q   <= '0;
        end else begin
            if (paint_start) begin
                frame_cnt_q <= frame_cnt_q + 1'b1;
            end
            if (overrun) begin
                ovr_cnt_q <= sat_inc_ovr(ovr_cnt_q);
            end
        end
    end

    assign frame_count   = frame_cnt_q;
    assign overrun_count = ovr_cnt_q;
`else
    assign frame_count   = '0;
    assign overrun_count = '0;
`endif

endmodule
